ask2_pio_ext: RTL and testbench
===============================

# ask2_pio_ext

Parametrised Avalon-MM general-purpose I/O slave for the ASK2 Nios subsystem, the successor to the fixed 16-bit output-only PIO. It provides:
- per-bit direction control;
- atomic bit set/clear;
- two-flop synchronised inputs;
- configurable edge capture with a maskable level interrupt to the CPU.

Register offset 0 stays write/read compatible with the legacy output-only PIO, so existing firmware works unchanged when all bits are outputs.

## Interface
Parameters:
- WIDTH, 16, number of I/O bits, legal range 1..32
- RESET_VALUE, 0, reset value of the output data register (WIDTH bits)
- DIR_RESET, all ones, reset value of the direction register; 1 = output
- EDGE_TYPE, 0, capture edge: 0 = rising, 1 = falling, 2 = any

Ports:
- clk  in  1  system clock
- reset_n  in  1  reset, asynchronous, active-low; clock clk
- address  in  3  register word offset
- chipselect  in  1  slave select
- write_n  in  1  write strobe, active-low
- writedata  in  32  write data; bits above WIDTH-1 ignored
- readdata  out  32  combinational read data; bits above WIDTH-1 always 0
- in_port  in  WIDTH  asynchronous pin inputs
- out_port  out  WIDTH  output data register
- oe  out  WIDTH  output enable per bit; equals the direction register
- irq  out  1  interrupt, active-high level

## Operation
A write occurs on a rising clk edge when chipselect=1 and write_n=0.

Register map:
- 0 DATA: write loads data_out. Read returns (data_out & dir) | (in_sync & ~dir).
- 1 DIR: read/write direction register.
- 2 IRQMASK: read/write interrupt mask; resets to 0.
- 3 EDGECAP: read returns the capture register. Writing 1 to a bit clears it (W1C); writing 0 leaves it unchanged.
- 4 OUTSET: write sets data_out bits where writedata=1. Reads 0.
- 5 OUTCLR: write clears data_out bits where writedata=1. Reads 0.
- 6: reserved; reads 0, writes ignored.
- 7 CAPS: read-only; {16'h0A52, 3'b0, EDGE_TYPE[1:0], 5'b0, WIDTH[5:0]}, with bits [15:0] packing EDGE_TYPE and WIDTH.

Input path:
- Synchronised by two flops: in_port -> s1 -> in_sync.
- A third flop holds in_prev for edge detection.
- Edge detect per bit:
  - rising: in_sync & ~in_prev
  - falling: ~in_sync & in_prev
  - any: XOR of in_sync and in_prev
- A detected edge sets the corresponding edgecap bit, regardless of that bit's direction.

Interrupt:
- irq = |(edgecap & irqmask), purely combinational from the registers.

Simultaneous events:
- A W1C clear and a new detected edge on the same bit in the same cycle: the set wins, and the bit remains 1.
- A DIR change does not alter data_out. out_port always reflects data_out irrespective of oe.

Reset:
- Asynchronous on reset_n low.
- data_out=RESET_VALUE, dir=DIR_RESET, irqmask=0, edgecap=0, s1/in_sync/in_prev=0. Consequently out_port=RESET_VALUE, oe=DIR_RESET, irq=0.
- Asserting reset mid-operation discards pending captures immediately.
- Because in_prev resets to 0, an input held high at release produces one rising edge roughly 2 cycles after release (EDGE_TYPE 0 or 2). This is intended and firmware clears edgecap at init.

## Timing
- Write to DATA/DIR/IRQMASK/OUTSET/OUTCLR: the register updates on the write edge, and out_port/oe change in the same cycle after that edge.
- Reads: zero wait states, zero read latency; readdata is combinational from address and the registers.
- Input latency: an in_port change sampled at edge N appears in in_sync after edge N+1 and is visible in DATA reads from then on. The edgecap bit sets at edge N+2, and irq rises after edge N+2 if the bit is masked on.
- EDGECAP W1C: the bit reads 0 the cycle after the write edge, and irq deasserts in that same cycle unless another captured bit is still masked on.
- Pulses shorter than one clk period may be missed; no minimum is guaranteed below 2 clk periods.

## Test plan
- Reset with WIDTH=16 and defaults -> out_port=0x0000, oe=0xFFFF, irq=0; a read at offset 7 returns 0x0A520010.
- Write 0x00F0 to DATA, then 0x0003 to OUTSET, then 0x0030 to OUTCLR -> out_port reads 0x00F0, then 0x00F3, then 0x00C3; reads at offsets 4 and 5 return 0.
- Set DIR=0x00FF and drive in_port=0xA500 -> after 2 edges a DATA read returns 0xA5C3 (data_out=0x00C3 on the low byte).
- EDGE_TYPE=0, IRQMASK=0x0100, raise in_port[8] -> edgecap=0x0100 and irq=1 two edges later. Write 0x0100 to EDGECAP -> irq=0 the next cycle. Raise in_port[9] (unmasked) -> edgecap bit 9 sets, irq stays 0.
- Same-cycle rising edge on bit 8 and W1C write of 0x0100 -> edgecap bit 8 stays 1 and irq stays 1.
- Assert reset_n low asynchronously mid-test with edgecap nonzero -> all outputs return to reset values immediately, without waiting for a clk edge.

Source files
------------

// File: rtl/ask2_pio_ext.sv
// ask2_pio_ext: parametrised Avalon-MM general-purpose I/O slave.
//
// Ports:
//   clk, reset_n        - system clock; reset is asynchronous and active-low
//   address[2:0]        - register word offset
//   chipselect, write_n - a write happens on a clk edge when chipselect=1, write_n=0
//   writedata[31:0]     - write data; bits above WIDTH-1 are ignored
//   readdata[31:0]      - combinational read data, zero wait states
//   in_port[WIDTH-1:0]  - asynchronous pin inputs
//   out_port[WIDTH-1:0] - output data register
//   oe[WIDTH-1:0]       - per-bit output enable (the direction register, 1 = output)
//   irq                 - level interrupt, |(edgecap & irqmask)
//
// Register map:
//   0 DATA     write: data_out; read: (data_out & dir) | (in_sync & ~dir)
//   1 DIR      read/write direction
//   2 IRQMASK  read/write interrupt mask
//   3 EDGECAP  read capture bits; write 1 to clear
//   4 OUTSET   write sets data_out bits; reads 0
//   5 OUTCLR   write clears data_out bits; reads 0
//   6          reserved
//   7 CAPS     read-only {16'h0A52, 3'b0, EDGE_TYPE[1:0], 5'b0, WIDTH[5:0]}
module ask2_pio_ext #(
  parameter int unsigned      WIDTH       = 16,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter logic [WIDTH-1:0] DIR_RESET   = '1,
  parameter int unsigned      EDGE_TYPE   = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] out_port,
  output logic [WIDTH-1:0] oe,
  output logic             irq
);

  typedef enum logic [2:0] {
    REG_DATA    = 3'd0,
    REG_DIR     = 3'd1,
    REG_IRQMASK = 3'd2,
    REG_EDGECAP = 3'd3,
    REG_OUTSET  = 3'd4,
    REG_OUTCLR  = 3'd5,
    REG_RSVD    = 3'd6,
    REG_CAPS    = 3'd7
  } reg_addr_e;

  localparam logic [1:0]  EDGE_BITS  = 2'(EDGE_TYPE);
  localparam logic [5:0]  WIDTH_BITS = 6'(WIDTH);
  localparam logic [31:0] CAPS_WORD  = {16'h0A52, 3'b000, EDGE_BITS, 5'b00000, WIDTH_BITS};

  logic [WIDTH-1:0] data_out_q, data_out_d;
  logic [WIDTH-1:0] dir_q,      dir_d;
  logic [WIDTH-1:0] irqmask_q,  irqmask_d;
  logic [WIDTH-1:0] edgecap_q,  edgecap_d;
  logic [WIDTH-1:0] s1_q,       s1_d;
  logic [WIDTH-1:0] in_sync_q,  in_sync_d;
  logic [WIDTH-1:0] in_prev_q,  in_prev_d;

  logic             wr_en;
  reg_addr_e        reg_addr;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] w1c_mask;
  logic [WIDTH-1:0] edge_det;

  assign reg_addr = reg_addr_e'(address);
  assign wr_en    = chipselect && !write_n;
  assign wdata    = writedata[WIDTH-1:0];

  // Upper writedata bits are architecturally ignored when WIDTH < 32.
  if (WIDTH < 32) begin : g_unused_wdata
    logic unused_wdata;
    assign unused_wdata = ^writedata[31:WIDTH];
  end

  // Edge detection on the synchronised input against its one-cycle-old copy.
  always_comb begin
    if (EDGE_TYPE == 0)      edge_det = in_sync_q & ~in_prev_q;
    else if (EDGE_TYPE == 1) edge_det = ~in_sync_q & in_prev_q;
    else                     edge_det = in_sync_q ^ in_prev_q;
  end

  always_comb begin
    // NOTE: every signal gets a default before the case so no latch is inferred.
    data_out_d = data_out_q;
    dir_d      = dir_q;
    irqmask_d  = irqmask_q;
    w1c_mask   = '0;
    s1_d       = in_port;
    in_sync_d  = s1_q;
    in_prev_d  = in_sync_q;

    if (wr_en) begin
      unique case (reg_addr)
        REG_DATA:    data_out_d = wdata;
        REG_DIR:     dir_d      = wdata;
        REG_IRQMASK: irqmask_d  = wdata;
        REG_EDGECAP: w1c_mask   = wdata;
        REG_OUTSET:  data_out_d = data_out_q | wdata;
        REG_OUTCLR:  data_out_d = data_out_q & ~wdata;
        default:     ;
      endcase
    end

    // Set is applied after clear so a coincident edge keeps the bit at 1.
    edgecap_d = (edgecap_q & ~w1c_mask) | edge_det;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: every state register takes an explicit reset value; there is no
    // memory here, so nothing is left to power up undefined.
    if (!reset_n) begin
      data_out_q <= RESET_VALUE;
      dir_q      <= DIR_RESET;
      irqmask_q  <= '0;
      edgecap_q  <= '0;
      s1_q       <= '0;
      in_sync_q  <= '0;
      in_prev_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments so all flops sample the same old values.
      data_out_q <= data_out_d;
      dir_q      <= dir_d;
      irqmask_q  <= irqmask_d;
      edgecap_q  <= edgecap_d;
      s1_q       <= s1_d;
      in_sync_q  <= in_sync_d;
      in_prev_q  <= in_prev_d;
    end
  end

  always_comb begin
    readdata = '0;
    unique case (reg_addr)
      REG_DATA:    readdata[WIDTH-1:0] = (data_out_q & dir_q) | (in_sync_q & ~dir_q);
      REG_DIR:     readdata[WIDTH-1:0] = dir_q;
      REG_IRQMASK: readdata[WIDTH-1:0] = irqmask_q;
      REG_EDGECAP: readdata[WIDTH-1:0] = edgecap_q;
      REG_CAPS:    readdata            = CAPS_WORD;
      default:     readdata            = '0;
    endcase
  end

  assign out_port = data_out_q;
  assign oe       = dir_q;
  assign irq      = |(edgecap_q & irqmask_q);

endmodule

// File: tb/tb_ask2_pio_ext.sv
// Testbench for ask2_pio_ext (WIDTH=16, default parameters).
// Stimulus pushes expected values into a scoreboard queue; a monitor on the
// falling clock edge pops each entry and compares it with the live DUT output.
module tb_ask2_pio_ext;

  localparam int SEL_RD  = 0;
  localparam int SEL_OUT = 1;
  localparam int SEL_OE  = 2;
  localparam int SEL_IRQ = 3;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [15:0] in_port;
  logic [15:0] out_port;
  logic [15:0] oe;
  logic        irq;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    string       name;
    int          sel;
    logic [31:0] exp;
  } exp_t;

  exp_t sb_q[$];

  ask2_pio_ext #(.WIDTH(16)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .in_port    (in_port),
    .out_port   (out_port),
    .oe         (oe),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  // Monitor: samples away from the active edge and checks every queued entry.
  always @(negedge clk) begin
    exp_t        e;
    logic [31:0] act;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      case (e.sel)
        SEL_RD:  act = readdata;
        SEL_OUT: act = {16'h0, out_port};
        SEL_OE:  act = {16'h0, oe};
        default: act = {31'h0, irq};
      endcase
      n_checks++;
      if (act !== e.exp) begin
        n_fail++;
        $display("FAIL %s: got 0x%08h, expected 0x%08h", e.name, act, e.exp);
      end
    end
  end

  task automatic push(input string name, input int sel, input logic [31:0] exp);
    exp_t e;
    e.name = name;
    e.sel  = sel;
    e.exp  = exp;
    sb_q.push_back(e);
  endtask

  task automatic drain();
    for (int i = 0; i < 4 && sb_q.size() != 0; i++) begin
      @(negedge clk);
      #1;
    end
    if (sb_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d entries pending, expected 0", sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic rd(input logic [2:0] addr, input logic [31:0] exp, input string name);
    address    = addr;
    chipselect = 1'b1;
    push(name, SEL_RD, exp);
    drain();
    chipselect = 1'b0;
  endtask

  task automatic wr(input logic [2:0] addr, input logic [31:0] data);
    @(posedge clk);
    #1;
    address    = addr;
    writedata  = data;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(posedge clk);
    #1;
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n    = 1'b0;
    address    = 3'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = 32'h0;
    in_port    = 16'h0;
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;

    // Reset state and capability word.
    push("reset_out", SEL_OUT, 32'h0000);
    push("reset_oe",  SEL_OE,  32'h0000_FFFF);
    push("reset_irq", SEL_IRQ, 32'h0);
    rd(3'd7, 32'h0A52_0010, "caps");
    rd(3'd2, 32'h0, "reset_irqmask");

    // DATA / OUTSET / OUTCLR.
    wr(3'd0, 32'h0000_00F0);
    push("data_out", SEL_OUT, 32'h00F0);
    rd(3'd0, 32'h0000_00F0, "data_rd");
    wr(3'd4, 32'hFFFF_0003);
    push("outset_out", SEL_OUT, 32'h00F3);
    drain();
    wr(3'd5, 32'h0000_0030);
    push("outclr_out", SEL_OUT, 32'h00C3);
    drain();
    rd(3'd4, 32'h0, "outset_rd0");
    rd(3'd5, 32'h0, "outclr_rd0");
    rd(3'd6, 32'h0, "rsvd_rd0");

    // Direction change and synchronised input path.
    wr(3'd1, 32'h0000_00FF);
    push("dir_oe",  SEL_OE,  32'h00FF);
    push("dir_out", SEL_OUT, 32'h00C3);
    rd(3'd1, 32'h0000_00FF, "dir_rd");
    in_port = 16'hA500;
    repeat (2) @(posedge clk);
    #1;
    rd(3'd0, 32'h0000_A5C3, "data_mixed");
    @(posedge clk);
    #1;
    push("edge_nomask_irq", SEL_IRQ, 32'h0);
    rd(3'd3, 32'h0000_A500, "edgecap_rise");

    // Clear captures; falling edges must not capture with rising-edge mode.
    wr(3'd3, 32'h0000_FFFF);
    rd(3'd3, 32'h0, "edgecap_w1c_all");
    in_port = 16'h0000;
    repeat (3) @(posedge clk);
    #1;
    rd(3'd3, 32'h0, "edgecap_no_fall");

    // Masked rising edge on bit 8 raises irq two edges after sampling.
    wr(3'd2, 32'h0000_0100);
    rd(3'd2, 32'h0000_0100, "irqmask_rd");
    in_port = 16'h0100;
    repeat (2) @(posedge clk);
    #1;
    push("irq_before_cap", SEL_IRQ, 32'h0);
    drain();
    @(posedge clk);
    #1;
    push("irq_on_cap", SEL_IRQ, 32'h1);
    rd(3'd3, 32'h0000_0100, "edgecap_bit8");

    // W1C drops irq the next cycle.
    wr(3'd3, 32'h0000_0100);
    push("irq_after_w1c", SEL_IRQ, 32'h0);
    rd(3'd3, 32'h0, "edgecap_after_w1c");

    // Unmasked capture on bit 9 leaves irq low.
    in_port = 16'h0300;
    repeat (3) @(posedge clk);
    #1;
    push("irq_unmasked", SEL_IRQ, 32'h0);
    rd(3'd3, 32'h0000_0200, "edgecap_bit9");

    // Coincident W1C and new rising edge on bit 8: set wins; bit 9 clears.
    in_port = 16'h0200;
    repeat (3) @(posedge clk);
    #1;
    in_port = 16'h0300;
    repeat (2) @(posedge clk);
    #1;
    address    = 3'd3;
    writedata  = 32'h0000_0300;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(posedge clk);
    #1;
    chipselect = 1'b0;
    write_n    = 1'b1;
    push("irq_collision", SEL_IRQ, 32'h1);
    rd(3'd3, 32'h0000_0100, "edgecap_collision");

    // Asynchronous reset mid-cycle; checked before any further rising edge.
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    push("async_out", SEL_OUT, 32'h0000);
    push("async_oe",  SEL_OE,  32'h0000_FFFF);
    push("async_irq", SEL_IRQ, 32'h0);
    rd(3'd3, 32'h0, "async_edgecap");
    rd(3'd2, 32'h0, "async_irqmask");

    // Input held high at release produces one rising capture.
    reset_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rd(3'd3, 32'h0, "release_pre_cap");
    @(posedge clk);
    #1;
    rd(3'd3, 32'h0000_0300, "release_cap");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
